vmop_issue: RTL and testbench

VMOP_ISSUE -- requirements
Module: vmop_issue

---
 rtl/vmop_issue.sv | 157 +++++++++++++++
 tb/tb_vmop_issue.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vmop_issue.sv
// Mask-op issue sequencer: streams N operand beats from the register file into a
// pipelined mask unit, tracks in-flight beats, and writes results back.
module vmop_issue #(
  parameter int DATA_WIDTH  = 64,
  parameter int ADDR_WIDTH  = 32,
  parameter int OPSEL_WIDTH = 3,
  parameter int BEATS_WIDTH = 8,
  parameter int OUTS_WIDTH  = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [OPSEL_WIDTH-1:0] cmd_opSel,
  input  logic [ADDR_WIDTH-1:0]  cmd_vs1,
  input  logic [ADDR_WIDTH-1:0]  cmd_vs2,
  input  logic [ADDR_WIDTH-1:0]  cmd_vd,
  input  logic [BEATS_WIDTH-1:0] cmd_beats,
  output logic                   rd_en,
  output logic [ADDR_WIDTH-1:0]  rd_addr0,
  output logic [ADDR_WIDTH-1:0]  rd_addr1,
  input  logic [DATA_WIDTH-1:0]  rd_data0,
  input  logic [DATA_WIDTH-1:0]  rd_data1,
  output logic                   mop_valid,
  output logic [ADDR_WIDTH-1:0]  mop_addr,
  output logic [DATA_WIDTH-1:0]  mop_m0,
  output logic [DATA_WIDTH-1:0]  mop_m1,
  output logic [OPSEL_WIDTH-1:0] mop_opSel,
  input  logic                   resp_valid,
  input  logic [ADDR_WIDTH-1:0]  resp_addr,
  input  logic [DATA_WIDTH-1:0]  resp_vec,
  output logic                   wr_en,
  output logic [ADDR_WIDTH-1:0]  wr_addr,
  output logic [DATA_WIDTH-1:0]  wr_data,
  output logic                   busy,
  output logic                   done
);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN} state_t;

  state_t                 r_state;
  state_t                 w_state_next;
  logic [OPSEL_WIDTH-1:0] r_opsel;
  logic [ADDR_WIDTH-1:0]  r_vs1;
  logic [ADDR_WIDTH-1:0]  r_vs2;
  logic [ADDR_WIDTH-1:0]  r_vd;
  logic [BEATS_WIDTH-1:0] r_beats;
  logic [BEATS_WIDTH-1:0] r_idx;
  logic                   r_mop_valid;
  logic [ADDR_WIDTH-1:0]  r_mop_addr;
  logic [OUTS_WIDTH-1:0]  r_outs;
  logic [OUTS_WIDTH-1:0]  w_outs_next;
  logic                   r_wr_en;
  logic [ADDR_WIDTH-1:0]  r_wr_addr;
  logic [DATA_WIDTH-1:0]  r_wr_data;
  logic                   r_done;
  logic                   w_done_next;
  logic                   w_accept;
  logic                   w_in_read;
  logic [ADDR_WIDTH-1:0]  w_idx_ext;

  assign w_accept  = cmd_valid && (r_state == S_IDLE);
  assign w_in_read = (r_state == S_READ);
  assign w_idx_ext = ADDR_WIDTH'(r_idx);

  // Pending beats in the mask unit; a simultaneous issue and return cancel out.
  always_comb begin
    w_outs_next = r_outs;
    case ({r_mop_valid, resp_valid})
      2'b10:   w_outs_next = r_outs + OUTS_WIDTH'(1);
      2'b01:   w_outs_next = (r_outs == '0) ? '0 : r_outs - OUTS_WIDTH'(1);
      default: w_outs_next = r_outs;
    endcase
  end

  always_comb begin
    w_state_next = r_state;
    w_done_next  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (cmd_beats != '0) w_state_next = S_READ;
          else                 w_done_next  = 1'b1;
        end
      end
      S_READ: begin
        if (r_idx == r_beats - BEATS_WIDTH'(1)) w_state_next = S_DRAIN;
      end
      S_DRAIN: begin
        if (!r_mop_valid && (w_outs_next == '0)) begin
          w_state_next = S_IDLE;
          w_done_next  = 1'b1;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_opsel     <= '0;
      r_vs1       <= '0;
      r_vs2       <= '0;
      r_vd        <= '0;
      r_beats     <= '0;
      r_idx       <= '0;
      r_mop_valid <= 1'b0;
      r_mop_addr  <= '0;
      r_outs      <= '0;
      r_wr_en     <= 1'b0;
      r_wr_addr   <= '0;
      r_wr_data   <= '0;
      r_done      <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_done  <= w_done_next;
      r_outs  <= w_outs_next;
      if (w_accept) begin
        r_opsel <= cmd_opSel;
        r_vs1   <= cmd_vs1;
        r_vs2   <= cmd_vs2;
        r_vd    <= cmd_vd;
        r_beats <= cmd_beats;
        r_idx   <= '0;
      end else if (w_in_read) begin
        r_idx <= r_idx + BEATS_WIDTH'(1);
      end
      // Register file returns data one cycle after the strobe, so the request
      // qualifier and its destination address are delayed to line up with it.
      r_mop_valid <= w_in_read;
      r_mop_addr  <= w_in_read ? r_vd + w_idx_ext : '0;
      r_wr_en     <= resp_valid;
      r_wr_addr   <= resp_valid ? resp_addr : '0;
      r_wr_data   <= resp_valid ? resp_vec : '0;
    end
  end

  assign cmd_ready = (r_state == S_IDLE);
  assign busy      = (r_state != S_IDLE);
  assign done      = r_done;

  assign rd_en     = w_in_read;
  assign rd_addr0  = w_in_read ? r_vs1 + w_idx_ext : '0;
  assign rd_addr1  = w_in_read ? r_vs2 + w_idx_ext : '0;

  assign mop_valid = r_mop_valid;
  assign mop_addr  = r_mop_addr;
  assign mop_m0    = r_mop_valid ? rd_data0 : '0;
  assign mop_m1    = r_mop_valid ? rd_data1 : '0;
  assign mop_opSel = r_mop_valid ? r_opsel : '0;

  assign wr_en     = r_wr_en;
  assign wr_addr   = r_wr_addr;
  assign wr_data   = r_wr_data;

endmodule

// File: tb/tb_vmop_issue.sv
// Directed bench for vmop_issue with a one-cycle register file and a
// six-cycle mask unit model.
module tb_vmop_issue;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_opSel;
  logic [31:0] cmd_vs1, cmd_vs2, cmd_vd;
  logic [7:0]  cmd_beats;
  logic        rd_en;
  logic [31:0] rd_addr0, rd_addr1;
  logic [63:0] rd_data0 = '0, rd_data1 = '0;
  logic        mop_valid;
  logic [31:0] mop_addr;
  logic [63:0] mop_m0, mop_m1;
  logic [2:0]  mop_opSel;
  logic        resp_valid;
  logic [31:0] resp_addr;
  logic [63:0] resp_vec;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [63:0] wr_data;
  logic        busy, done;

  int total = 0;
  int bad   = 0;

  vmop_issue dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_opSel(cmd_opSel),
    .cmd_vs1(cmd_vs1), .cmd_vs2(cmd_vs2), .cmd_vd(cmd_vd), .cmd_beats(cmd_beats),
    .rd_en(rd_en), .rd_addr0(rd_addr0), .rd_addr1(rd_addr1),
    .rd_data0(rd_data0), .rd_data1(rd_data1),
    .mop_valid(mop_valid), .mop_addr(mop_addr), .mop_m0(mop_m0), .mop_m1(mop_m1),
    .mop_opSel(mop_opSel),
    .resp_valid(resp_valid), .resp_addr(resp_addr), .resp_vec(resp_vec),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] rf(input logic [31:0] a);
    if (a == 32'h10) return 64'hF0F0;
    if (a == 32'h20) return 64'hFF00;
    return {a ^ 32'h5A5A0000, ~a};
  endfunction

  function automatic logic [63:0] mask_op(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
    case (op)
      3'd0:    return a & b;
      3'd1:    return a | b;
      3'd2:    return a ^ b;
      3'd3:    return a & ~b;
      default: return ~(a ^ b);
    endcase
  endfunction

  // Register file: one-cycle read latency.
  always @(posedge clk) begin
    if (rd_en) begin
      rd_data0 <= rf(rd_addr0);
      rd_data1 <= rf(rd_addr1);
    end
  end

  // Mask unit: request seen at cycle C returns as a response in cycle C+6.
  logic        mv[6];
  logic [31:0] ma[6];
  logic [63:0] md[6];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 6; i++) mv[i] <= 1'b0;
    end else begin
      mv[0] <= mop_valid;
      ma[0] <= mop_addr;
      md[0] <= mask_op(mop_opSel, mop_m0, mop_m1);
      for (int i = 1; i < 6; i++) begin
        mv[i] <= mv[i-1];
        ma[i] <= ma[i-1];
        md[i] <= md[i-1];
      end
    end
  end
  assign resp_valid = mv[5];
  assign resp_addr  = ma[5];
  assign resp_vec   = md[5];

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic set_cmd(input logic v, input logic [2:0] op, input logic [31:0] a1,
                         input logic [31:0] a2, input logic [31:0] d, input logic [7:0] n);
    cmd_valid = v; cmd_opSel = op; cmd_vs1 = a1; cmd_vs2 = a2; cmd_vd = d; cmd_beats = n;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_cmd(1'b0, 3'd0, 32'h0, 32'h0, 32'h0, 8'd0);
    tick(); tick();
    total++;
    if ({rd_en, mop_valid, wr_en, done, busy} !== 5'b0) begin
      bad++; $display("FAIL reset_strobes got=%b exp=00000", {rd_en, mop_valid, wr_en, done, busy});
    end
    total++;
    if ((|{rd_addr0, rd_addr1, mop_addr, mop_m0, mop_m1, mop_opSel, wr_addr, wr_data}) !== 1'b0) begin
      bad++; $display("FAIL reset_data got=nonzero exp=0");
    end
    total++;
    if (cmd_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", cmd_ready); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single();
    set_cmd(1'b1, 3'd0, 32'h10, 32'h20, 32'h30, 8'd1);
    total++;
    if (cmd_ready !== 1'b1) begin bad++; $display("FAIL single_ready got=%b exp=1", cmd_ready); end
    tick(); cmd_valid = 1'b0;
    total++;
    if ({rd_en, busy, cmd_ready} !== 3'b110 || rd_addr0 !== 32'h10 || rd_addr1 !== 32'h20) begin
      bad++; $display("FAIL single_read got=%b/%h/%h exp=110/10/20", {rd_en, busy, cmd_ready}, rd_addr0, rd_addr1);
    end
    tick();
    total++;
    if (mop_valid !== 1'b1 || mop_addr !== 32'h30 || mop_m0 !== 64'hF0F0 || mop_m1 !== 64'hFF00 ||
        mop_opSel !== 3'd0 || rd_en !== 1'b0) begin
      bad++; $display("FAIL single_mop got=%b/%h/%h/%h exp=1/30/f0f0/ff00", mop_valid, mop_addr, mop_m0, mop_m1);
    end
    for (int k = 3; k <= 8; k++) begin
      tick();
      total++;
      if ({wr_en, done, busy, mop_valid} !== 4'b0010) begin
        bad++; $display("FAIL single_wait k=%0d got=%b exp=0010", k, {wr_en, done, busy, mop_valid});
      end
    end
    tick();
    total++;
    if ({wr_en, done, cmd_ready, busy} !== 4'b1110 || wr_addr !== 32'h30 || wr_data !== 64'hF000) begin
      bad++; $display("FAIL single_done got=%b/%h/%h exp=1110/30/f000", {wr_en, done, cmd_ready, busy}, wr_addr, wr_data);
    end
    tick();
    total++;
    if ({wr_en, done} !== 2'b00 || wr_addr !== 32'h0 || wr_data !== 64'h0) begin
      bad++; $display("FAIL single_after got=%b/%h/%h exp=00/0/0", {wr_en, done}, wr_addr, wr_data);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_a;
    logic [63:0] exp_d;
    set_cmd(1'b1, 3'd2, 32'h10, 32'h20, 32'h30, 8'd4);
    total++;
    if (cmd_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready got=%b exp=1", cmd_ready); end
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (k == 1) cmd_valid = 1'b0;
      total++;
      if (rd_en !== (k <= 4) || cmd_ready !== (k == 12) || done !== (k == 12) || wr_en !== (k >= 9)) begin
        bad++; $display("FAIL b2b_ctl k=%0d got=%b%b%b%b", k, rd_en, cmd_ready, done, wr_en);
      end
      if (k <= 4) begin
        exp_a = 32'h10 + 32'(k - 1);
        total++;
        if (rd_addr0 !== exp_a) begin bad++; $display("FAIL b2b_rdaddr k=%0d got=%h exp=%h", k, rd_addr0, exp_a); end
      end
      if (k >= 9) begin
        exp_a = 32'h30 + 32'(k - 9);
        exp_d = rf(32'h10 + 32'(k - 9)) ^ rf(32'h20 + 32'(k - 9));
        total++;
        if (wr_addr !== exp_a || wr_data !== exp_d) begin
          bad++; $display("FAIL b2b_wr k=%0d got=%h/%h exp=%h/%h", k, wr_addr, wr_data, exp_a, exp_d);
        end
      end
    end
    tick();
    total++;
    if (done !== 1'b0) begin bad++; $display("FAIL b2b_done_pulse got=%b exp=0", done); end
  endtask

  task automatic test_zero();
    set_cmd(1'b1, 3'd1, 32'h44, 32'h55, 32'h66, 8'd0);
    tick(); cmd_valid = 1'b0;
    total++;
    if ({done, cmd_ready, busy, rd_en} !== 4'b1100) begin
      bad++; $display("FAIL zero_done got=%b exp=1100", {done, cmd_ready, busy, rd_en});
    end
    for (int k = 2; k <= 10; k++) begin
      tick();
      total++;
      if ({rd_en, mop_valid, wr_en, done, busy, cmd_ready} !== 6'b000001) begin
        bad++; $display("FAIL zero_quiet k=%0d got=%b exp=000001", k, {rd_en, mop_valid, wr_en, done, busy, cmd_ready});
      end
    end
  endtask

  task automatic test_wrap();
    int n;
    set_cmd(1'b1, 3'd1, 32'hFFFFFFFF, 32'h100, 32'h200, 8'd2);
    tick(); cmd_valid = 1'b0;
    total++;
    if (rd_addr0 !== 32'hFFFFFFFF) begin bad++; $display("FAIL wrap_first got=%h exp=ffffffff", rd_addr0); end
    tick();
    total++;
    if (rd_addr0 !== 32'h0 || rd_en !== 1'b1) begin bad++; $display("FAIL wrap_second got=%h exp=00000000", rd_addr0); end
    n = 2;
    do begin tick(); n++; end while (done !== 1'b1 && n < 40);
    total++;
    if (n !== 10) begin bad++; $display("FAIL wrap_done_cycle got=%0d exp=10", n); end
  endtask

  task automatic test_reset_abort();
    int n;
    set_cmd(1'b1, 3'd0, 32'h40, 32'h48, 32'h50, 8'd8);
    tick(); cmd_valid = 1'b0;
    tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++;
    if ({rd_en, mop_valid, wr_en, done, busy, cmd_ready} !== 6'b000001) begin
      bad++; $display("FAIL abort_ctl got=%b exp=000001", {rd_en, mop_valid, wr_en, done, busy, cmd_ready});
    end
    total++;
    if ((|{rd_addr0, rd_addr1, mop_addr, mop_m0, mop_m1, mop_opSel, wr_addr, wr_data}) !== 1'b0) begin
      bad++; $display("FAIL abort_data got=nonzero exp=0");
    end
    tick();
    total++;
    if (wr_en !== 1'b0 || cmd_ready !== 1'b1) begin
      bad++; $display("FAIL abort_after got=%b%b exp=01", wr_en, cmd_ready);
    end
    set_cmd(1'b1, 3'd0, 32'h10, 32'h20, 32'h58, 8'd1);
    n = 0;
    do begin tick(); cmd_valid = 1'b0; n++; end while (done !== 1'b1 && n < 40);
    total++;
    if (n !== 9 || wr_en !== 1'b1 || wr_addr !== 32'h58 || wr_data !== 64'hF000) begin
      bad++; $display("FAIL abort_restart got=%0d/%b/%h/%h exp=9/1/58/f000", n, wr_en, wr_addr, wr_data);
    end
  endtask

  task automatic test_hold();
    int n;
    set_cmd(1'b1, 3'd3, 32'h60, 32'h70, 32'h80, 8'd2);
    tick();
    set_cmd(1'b1, 3'd0, 32'h90, 32'hA0, 32'hB0, 8'd1);
    for (int k = 1; k <= 9; k++) begin
      total++;
      if (cmd_ready !== 1'b0) begin bad++; $display("FAIL hold_ready k=%0d got=%b exp=0", k, cmd_ready); end
      tick();
    end
    total++;
    if (cmd_ready !== 1'b1 || done !== 1'b1) begin
      bad++; $display("FAIL hold_accept got=%b%b exp=11", cmd_ready, done);
    end
    tick(); cmd_valid = 1'b0;
    total++;
    if (rd_en !== 1'b1 || rd_addr0 !== 32'h90 || rd_addr1 !== 32'hA0) begin
      bad++; $display("FAIL hold_second_read got=%b/%h/%h exp=1/90/a0", rd_en, rd_addr0, rd_addr1);
    end
    n = 1;
    do begin tick(); n++; end while (done !== 1'b1 && n < 40);
    total++;
    if (n !== 9 || wr_addr !== 32'hB0) begin
      bad++; $display("FAIL hold_second_done got=%0d/%h exp=9/b0", n, wr_addr);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_zero();
    test_wrap();
    test_reset_abort();
    test_hold();
    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
